// File: rtl/muldiv_seq.sv
// muldiv_seq: unsigned RV32M MUL/MULHU/DIVU/REMU sequencer.
// Performs one shift-add (multiply) or restoring-subtract (divide) step per cycle
// through the shared execute ALU, 32 steps per operation.
module muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_c,
    input  logic [XLEN-1:0] alu_y
);

    localparam int unsigned CNT_W = $clog2(STEPS);
    localparam int unsigned ALU_W = 5;

    // ALU op codes, same encoding as the execute stage's format.vh
    localparam logic [ALU_W-1:0] ALU_IADD = 5'h00;
    localparam logic [ALU_W-1:0] ALU_ISUB = 5'h01;
    localparam logic [ALU_W-1:0] ALU_IPAS = 5'h0F;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    // acc holds hi (multiply) or rem (divide); sh holds lo or quo; opnd holds mc or dv
    logic [XLEN-1:0]  acc, acc_nxt;
    logic [XLEN-1:0]  sh, sh_nxt;
    logic [XLEN-1:0]  opnd, opnd_nxt;
    logic [XLEN-1:0]  res_nxt;
    logic [XLEN:0]    s;
    logic             is_div;
    logic             carry;
    logic             ge;

    assign is_div = op_q[1];
    assign s      = {acc, sh[XLEN-1]};
    assign carry  = (alu_y < acc);
    assign ge     = s[XLEN] | (s[XLEN-1:0] >= opnd);

    // ALU drive: depends only on registered state so alu_y feedback is loop-free
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_c = ALU_IPAS;
        if (state == S_RUN) begin
            if (is_div) begin
                alu_a = s[XLEN-1:0];
                alu_b = opnd;
                alu_c = ALU_ISUB;
            end else begin
                alu_a = acc;
                alu_b = sh[0] ? opnd : '0;
                alu_c = ALU_IADD;
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        sh_nxt    = sh;
        opnd_nxt  = opnd;
        res_nxt   = result;
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_nxt  = op;
                    cnt_nxt = '0;
                    acc_nxt = '0;
                    if (op[1]) begin
                        sh_nxt   = a;
                        opnd_nxt = b;
                    end else begin
                        sh_nxt   = b;
                        opnd_nxt = a;
                    end
                    if (op[1] && (b == '0)) begin
                        state_nxt = S_DONE;
                        res_nxt   = op[0] ? a : '1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (is_div) begin
                    acc_nxt = ge ? alu_y : s[XLEN-1:0];
                    sh_nxt  = {sh[XLEN-2:0], ge};
                end else begin
                    acc_nxt = {carry, alu_y[XLEN-1:1]};
                    sh_nxt  = {alu_y[0], sh[XLEN-1:1]};
                end
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(STEPS - 1)) begin
                    state_nxt = S_DONE;
                    // MUL/DIVU take the shifted register, MULHU/REMU the accumulator
                    res_nxt   = op_q[0] ? acc_nxt : sh_nxt;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            sh     <= '0;
            opnd   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            sh     <= sh_nxt;
            opnd   <= opnd_nxt;
            result <= res_nxt;
            busy   <= (state_nxt == S_RUN);
            done   <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: behavioural ALU, queue scoreboard, directed + random ops.
module tb_muldiv_seq;

    localparam logic [4:0] ALU_IADD = 5'h00;
    localparam logic [4:0] ALU_ISUB = 5'h01;
    localparam logic [4:0] ALU_IPAS = 5'h0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_y;
    logic [4:0]  alu_c;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    muldiv_seq #(.XLEN(32), .STEPS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_y(alu_y)
    );

    always #5 clk = ~clk;

    // Shared execute ALU model
    always_comb begin
        case (alu_c)
            ALU_IADD: alu_y = alu_a + alu_b;
            ALU_ISUB: alu_y = alu_a - alu_b;
            default:  alu_y = alu_a;
        endcase
    end

    // Reference results straight from RV32M arithmetic
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: idle ALU drive, and pop/compare on every done pulse
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (busy === 1'b0) begin
                check("idle_alu_a", alu_a, 32'd0);
                check("idle_alu_b", alu_b, 32'd0);
                check("idle_alu_c", 32'(alu_c), 32'(ALU_IPAS));
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 with result %h, expected no pending op", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp;
        logic        div0;
        int          lat;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp  = ref_model(o, x, y);
        div0 = o[1] && (y == 32'd0);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
        check("busy_after_start", 32'(busy), div0 ? 32'd0 : 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_latency", 32'(lat), div0 ? 32'd0 : 32'd32);
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_hold", result, exp);
    endtask

    logic [1:0]  d_op[14] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3,
                              2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] d_a[14]  = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'd5, 32'd0, 32'h1234_5678};
    logic [31:0] d_b[14]  = '{32'd6, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                              32'd3, 32'd3, 32'h8000_0001, 32'h8000_0001,
                              32'd0, 32'd0, 32'hDEAD_BEEF, 32'd1};

    initial begin
        int lat;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_alu_c", 32'(alu_c), 32'(ALU_IPAS));
        rst = 1'b0;

        for (int i = 0; i < 14; i++) do_op(d_op[i], d_a[i], d_b[i]);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3, 0))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(15, 1));
                default: rb = $urandom;
            endcase
            do_op(2'($urandom), $urandom, rb);
        end

        // Start while busy is ignored: single done with the first op's result
        @(negedge clk);
        op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
        exp_q.push_back(32'd12);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'd2; a = 32'd9; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 10;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_start_latency", 32'(lat), 32'd32);
        repeat (6) @(posedge clk);
        #1;
        check("busy_start_result_held", result, 32'd12);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        exp_q.push_back(32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_alu_c", 32'(alu_c), 32'(ALU_IPAS));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_op(2'd0, 32'd2, 32'd2);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer that implements unsigned RV32M multiply and divide (MUL, MULHU, DIVU, REMU) by driving the shared combinational ALU one add or subtract per cycle.
- Sits beside the execute stage: the decoder raises start with operands; the pipeline stalls on busy and takes result on done.
- Owns the ALU A/B/C inputs only while busy; the execute mux selects this block's ALU drive when busy=1.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
STEPS, 32, iterations per operation (= XLEN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
a  input  32  multiplicand / dividend
b  input  32  multiplier / divisor
busy  output  1  high in RUN state
done  output  1  one-cycle pulse, result valid
result  output  32  registered result, held until next accepted start
alu_a  output  32  to ALU A
alu_b  output  32  to ALU B
alu_c  output  5  to ALU C (format.vh op code)
alu_y  input  32  from ALU Y (combinational)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst asserted at any time -> IDLE, busy=0, done=0, result=0, all internal registers 0, even mid-operation.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch op, a, b and count=0.
  - Divisor zero (op 10/11 with b=0) -> go directly to DONE; DIVU result=0xFFFFFFFF, REMU result=a.
  - Otherwise -> RUN.
- RUN: one step per edge, count 0..31.
  - After step 31, the final value is written to result and the block enters DONE.
  - Nominal path: busy high edge k..k+32; done high in cycle k+32..k+33.
  - Div-by-zero path: done high in cycle k+1..k+2.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored, as is a start in RUN; there is no queueing.
- ALU drive outside RUN: alu_a=0, alu_b=0, alu_c=`IPAS.
- Multiply step (op 00/01): regs hi=0, lo=b, mc=a at start.
  - alu_a=hi, alu_b = lo[0] ? mc : 0, alu_c=`IADD.
  - carry = (alu_y < hi), computed by a local unsigned compare.
  - {hi,lo} <= {carry, alu_y, lo[31:1]}.
  - Final: MUL -> lo, MULHU -> hi.
- Divide step (op 10/11), restoring division: regs rem=0, quo=a, dv=b at start.
  - s = {rem, quo[31]} (33 bits).
  - alu_a=s[31:0], alu_b=dv, alu_c=`ISUB.
  - ge = s[32] | (s[31:0] >= dv), local unsigned compare; when s[32]=1 the low 32 bits of alu_y are still correct mod 2^32.
  - rem <= ge ? alu_y : s[31:0]; quo <= {quo[30:0], ge}.
  - Final: DIVU -> quo, REMU -> rem.
- Widths: all internal arithmetic is 32-bit through the ALU; the only wider quantity is the 33-bit s. No signed ops; signed variants are out of scope for this block.
- result changes only on the transition into DONE or on reset.
- Inputs a, b, op may change freely after the start edge without effect.

Test Plan:
- MUL a=7, b=6 -> busy 32 cycles, done pulse at k+32, result=0x0000002A; MULHU same operands -> 0x00000000.
- MUL / MULHU a=b=0xFFFFFFFF -> MUL result=0x00000001, MULHU result=0xFFFFFFFE; this exercises the carry on every step.
- DIVU a=100, b=7 -> result=14; REMU same -> 2. DIVU a=0x80000000, b=3 -> 0x2AAAAAAA; REMU -> 2. DIVU a=0xFFFFFFFF, b=0x80000001 -> 1; REMU -> 0x7FFFFFFE (covers s[32]=1).
- Divide by zero: DIVU a=5, b=0 -> done at k+1, result=0xFFFFFFFF, busy never high; REMU a=5, b=0 -> result=5.
- Start during busy: start MUL 3*4, pulse start with DIVU 9/3 at k+10 -> single done at k+32, result=12, no second done; result stays 12 in later idle cycles.
- Reset mid-op: assert rst at k+15 asynchronously (between edges) -> busy, done, result drop to 0 immediately. After release, new MUL 2*2 -> result=4 at k'+32. Also check alu_c=`IPAS and alu_a/alu_b=0 whenever IDLE.
